// File: rtl/rand_word_collector_pkg.sv
// Shared types and constants for the random word collector.
//   rand_state_e : collector FSM states
//   LFSR_SAMPLE  : LFSR state code that freezes the LFSR and samples its bit
//   LFSR_RUN     : LFSR state code that lets the LFSR advance
//   sat_inc16    : 16-bit increment that sticks at all-ones
package rand_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    SAMPLE,
    CHECK,
    HOLD
  } rand_state_e;

  localparam logic [2:0] LFSR_SAMPLE = 3'd2;
  localparam logic [2:0] LFSR_RUN    = 3'd0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rand_word_collector_if.sv
// Request/response bus between the game controller and the random word collector.
//   i_req      : request a new word (taken only while o_ready=1)
//   o_ready    : collector idle
//   i_limit    : exclusive upper bound for the word, 0 = full range
//   o_valid    : o_rand valid, held until i_ack
//   i_ack      : consumer takes the word
//   o_rand     : random word
//   o_fallback : word is the forced 0 after too many rejections
// master = game controller side, slave = collector side.
interface rand_word_collector_if #(
  parameter int unsigned WIDTH = 8
);

  logic             i_req;
  logic             o_ready;
  logic [WIDTH-1:0] i_limit;
  logic             o_valid;
  logic             i_ack;
  logic [WIDTH-1:0] o_rand;
  logic             o_fallback;

  modport master (
    output i_req,
    output i_limit,
    output i_ack,
    input  o_ready,
    input  o_valid,
    input  o_rand,
    input  o_fallback
  );

  modport slave (
    input  i_req,
    input  i_limit,
    input  i_ack,
    output o_ready,
    output o_valid,
    output o_rand,
    output o_fallback
  );

endinterface

// File: rtl/rand_bit_sampler.sv
// Bit sampler: alternates a shift phase (LFSR advances) and a sample phase
// (LFSR frozen, bit shifted into the word) until WIDTH bits are collected.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : begin a new word (first phase is shift, counter cleared)
//   i_bit          : LFSR output bit
//   o_sample       : current cycle is a sample phase
//   o_done         : current sample phase takes the last bit of the word
//   o_word         : collected word, first sampled bit in the MSB
module rand_bit_sampler
  import rand_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_bit,
  output logic             o_sample,
  output logic             o_done,
  output logic [WIDTH-1:0] o_word
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             active_q, active_d;
  logic             sample_q, sample_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             last_bit;

  assign last_bit = sample_q && (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    active_d = active_q;
    sample_d = sample_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    if (i_start) begin
      active_d = 1'b1;
      sample_d = 1'b0;
      cnt_d    = '0;
    end else if (active_q) begin
      if (sample_q) begin
        word_d   = {word_q[WIDTH-2:0], i_bit};
        cnt_d    = cnt_q + CNT_W'(1);
        sample_d = 1'b0;
        if (last_bit) begin
          active_d = 1'b0;
        end
      end else begin
        sample_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      active_q <= 1'b0;
      sample_q <= 1'b0;
      cnt_q    <= '0;
      word_q   <= '0;
    end else begin
      active_q <= active_d;
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
    end
  end

  assign o_sample = active_q && sample_q;
  assign o_done   = active_q && last_bit;
  assign o_word   = word_q;

endmodule

// File: rtl/rand_word_collector.sv
// Random word collector: drives the LFSR state input, deserializes its output
// into a WIDTH-bit word, optionally rejects words >= limit and hands the result
// to the game controller through a valid/ack handshake.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus            : request/response bus (slave side)
//   i_bit          : LFSR output bit
//   o_lfsr_state   : LFSR state input (LFSR_SAMPLE while sampling, else LFSR_RUN)
//   o_word_cnt     : handshakes completed, saturating  (RAND_STATS_EN only)
//   o_reject_cnt   : words rejected in CHECK, saturating (RAND_STATS_EN only)
// Macro RAND_STATS_EN adds the two statistics counters.
module rand_word_collector
  import rand_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_RETRY = 15
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  rand_word_collector_if.slave bus,
  input  logic                 i_bit,
  output logic [2:0]           o_lfsr_state
`ifdef RAND_STATS_EN
  ,
  output logic [15:0]          o_word_cnt,
  output logic [15:0]          o_reject_cnt
`endif
);

  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  rand_state_e        state_q, state_d;
  logic [WIDTH-1:0]   limit_q, limit_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [WIDTH-1:0]   rand_q, rand_d;
  logic               fb_q, fb_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;
  logic [2:0]         lfsr_q, lfsr_d;

  logic               smp_start;
  logic               smp_sample;
  logic               smp_done;
  logic [WIDTH-1:0]   smp_word;
  logic               in_range;
  logic               reject;

  rand_bit_sampler #(
    .WIDTH (WIDTH)
  ) u_sampler (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (smp_start),
    .i_bit    (i_bit),
    .o_sample (smp_sample),
    .o_done   (smp_done),
    .o_word   (smp_word)
  );

  assign in_range = (limit_q == '0) || (smp_word < limit_q);
  assign reject   = (state_q == CHECK) && !in_range;

  always_comb begin
    state_d   = state_q;
    limit_d   = limit_q;
    retry_d   = retry_q;
    rand_d    = rand_q;
    fb_d      = fb_q;
    smp_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_req) begin
          limit_d   = bus.i_limit;
          retry_d   = '0;
          smp_start = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        state_d = SAMPLE;
      end
      SAMPLE: begin
        // Phase tracking lives in the sampler; the FSM follows it.
        state_d = smp_done ? CHECK : (smp_sample ? SHIFT : SAMPLE);
      end
      CHECK: begin
        if (in_range) begin
          rand_d  = smp_word;
          fb_d    = 1'b0;
          state_d = HOLD;
        end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
          retry_d   = retry_q + RETRY_W'(1);
          smp_start = 1'b1;
          state_d   = SHIFT;
        end else begin
          rand_d  = '0;
          fb_d    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.i_ack) begin
          fb_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Outputs are registered from the next state so they line up with it.
    ready_d = (state_d == IDLE);
    valid_d = (state_d == HOLD);
    lfsr_d  = (state_d == SAMPLE) ? LFSR_SAMPLE : LFSR_RUN;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      limit_q <= '0;
      retry_q <= '0;
      rand_q  <= '0;
      fb_q    <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      lfsr_q  <= LFSR_RUN;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      retry_q <= retry_d;
      rand_q  <= rand_d;
      fb_q    <= fb_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign bus.o_ready    = ready_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_rand     = rand_q;
  assign bus.o_fallback = fb_q;
  assign o_lfsr_state   = lfsr_q;

`ifdef RAND_STATS_EN
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [15:0] reject_cnt_q, reject_cnt_d;

  always_comb begin
    word_cnt_d   = word_cnt_q;
    reject_cnt_d = reject_cnt_q;
    if ((state_q == HOLD) && bus.i_ack) begin
      word_cnt_d = sat_inc16(word_cnt_q);
    end
    if (reject) begin
      reject_cnt_d = sat_inc16(reject_cnt_q);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      word_cnt_q   <= '0;
      reject_cnt_q <= '0;
    end else begin
      word_cnt_q   <= word_cnt_d;
      reject_cnt_q <= reject_cnt_d;
    end
  end

  assign o_word_cnt   = word_cnt_q;
  assign o_reject_cnt = reject_cnt_q;
`else
  logic unused_reject;
  assign unused_reject = reject;
`endif

endmodule
